// File: rtl/uop_decode_table_pkg.sv
// Shared defaults, FSM state type and helpers for the ULPSH micro-op decode table.
// Sized so that the full opcode space and any control-word width can be derived from four numbers.
package ulpsh_uop_pkg;

   localparam int OPCODE_W_DEF = 9;
   localparam int SIGNAL_W_DEF = 46;
   localparam int NUM_OPS_DEF  = 81;
   localparam int BUS_W_DEF    = 16;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic [SIGNAL_W_DEF-1:0] NOP_WORD = '0;

   function automatic int nseg(input int signal_w, input int bus_w);
      return (signal_w + bus_w - 1) / bus_w;
   endfunction

endpackage

// File: rtl/uop_decode_table_ram.sv
// Opcode-indexed control-word store: one write port, one registered read-before-write read port.
// The array has no reset; the owner zeroes it by sweeping every entry.
module uop_table_ram #(
   parameter int DEPTH = 81,
   parameter int WIDTH = 46,
   parameter int AW    = 7
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Both updates are non-blocking, so a same-edge read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/uop_decode_table.sv
// Runtime-programmable micro-opcode decoder: opcode -> control word through a host-loadable table.
// Holds the init/clear sweep FSM, segment staging, range checks and the one-cycle decode pipeline.
module uop_decode_table
   import ulpsh_uop_pkg::*;
#(
   parameter int  OPCODE_W = OPCODE_W_DEF,
   parameter int  SIGNAL_W = SIGNAL_W_DEF,
   parameter int  NUM_OPS  = NUM_OPS_DEF,
   parameter int  BUS_W    = BUS_W_DEF,
   localparam int NSEG     = nseg(SIGNAL_W, BUS_W),
   localparam int SEG_W    = (NSEG > 1) ? $clog2(NSEG) : 1
)(
   input  logic                ClockIn,
   input  logic                ResetIn,
   input  logic                OpValid_i,
   input  logic [OPCODE_W-1:0] MicroOpCode_i,
   output logic [SIGNAL_W-1:0] Signals_o,
   output logic                SignalsValid_o,
   output logic                IllegalOp_o,
   output logic                Ready_o,
   input  logic                CfgWrEn_i,
   input  logic [OPCODE_W-1:0] CfgAddr_i,
   input  logic [SEG_W-1:0]    CfgSeg_i,
   input  logic [BUS_W-1:0]    CfgData_i,
   input  logic                CfgClear_i,
   output logic                CfgAck_o,
   output logic                CfgErr_o
);

   localparam int AW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int STG_W = (NSEG - 1) * BUS_W;

   state_t              state;
   logic [AW-1:0]       cnt;
   logic                ready_r;
   logic [STG_W-1:0]    staging;

   logic                accept_p0, legal_p0;
   logic                cfg_go, clr_go, seg_last, seg_stage, addr_ok, commit;
   logic [SIGNAL_W-1:0] commit_word;

   logic                we;
   logic [AW-1:0]       waddr;
   logic [SIGNAL_W-1:0] wdata;

   logic                vld_p1, ill_p1, ack_p1, err_p1;
   logic [SIGNAL_W-1:0] rdata_p1;

   // Stage p0: acceptance and range checks on the incoming opcode / config beat.
   // Everything is gated by the registered ready flag, so Ready_o means exactly "being accepted".
   assign accept_p0   = ready_r & OpValid_i;
   assign legal_p0    = {1'b0, MicroOpCode_i} < (OPCODE_W+1)'(NUM_OPS);
   assign clr_go      = ready_r & CfgClear_i;
   assign cfg_go      = ready_r & CfgWrEn_i & ~CfgClear_i;
   assign seg_last    = CfgSeg_i == SEG_W'(NSEG - 1);
   assign seg_stage   = CfgSeg_i <  SEG_W'(NSEG - 1);
   assign addr_ok     = {1'b0, CfgAddr_i} < (OPCODE_W+1)'(NUM_OPS);
   assign commit      = cfg_go & seg_last & addr_ok;
   assign commit_word = SIGNAL_W'({CfgData_i, staging});

   always_comb begin
      we    = 1'b0;
      waddr = cnt;
      wdata = '0;
      if (state == INIT) begin
         we = 1'b1;
      end else if (commit) begin
         we    = 1'b1;
         waddr = AW'(CfgAddr_i);
         wdata = commit_word;
      end
   end

   uop_table_ram #(
      .DEPTH (NUM_OPS),
      .WIDTH (SIGNAL_W),
      .AW    (AW)
   ) u_table (
      .clk   (ClockIn),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (accept_p0 & legal_p0),
      .raddr (AW'(MicroOpCode_i)),
      .rdata (rdata_p1)
   );

   always_ff @(posedge ClockIn or posedge ResetIn) begin
      if (ResetIn) begin
         state   <= INIT;
         cnt     <= '0;
         ready_r <= 1'b0;
         staging <= '0;
         vld_p1  <= 1'b0;
         ill_p1  <= 1'b0;
         ack_p1  <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         vld_p1 <= accept_p0;
         ill_p1 <= accept_p0 & ~legal_p0;
         ack_p1 <= cfg_go & seg_last;
         err_p1 <= cfg_go & seg_last & ~addr_ok;
         if (clr_go) begin
            state   <= INIT;
            cnt     <= '0;
            ready_r <= 1'b0;
            staging <= '0;
         end else begin
            ready_r <= (state == READY);
            if (state == INIT) begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(NUM_OPS - 1))
                  state <= READY;
            end
            if (cfg_go && seg_stage)
               staging[int'(CfgSeg_i)*BUS_W +: BUS_W] <= CfgData_i;
         end
      end
   end

   // Stage p1: registered decode result; illegal or idle slots present the NOP word.
   assign Signals_o      = (vld_p1 && !ill_p1) ? rdata_p1 : SIGNAL_W'(NOP_WORD);
   assign SignalsValid_o = vld_p1;
   assign IllegalOp_o    = ill_p1;
   assign Ready_o        = ready_r;
   assign CfgAck_o       = ack_p1;
   assign CfgErr_o       = err_p1;

endmodule

// File: tb/tb_uop_decode_table.sv
// Bench for uop_decode_table: table-driven vectors plus hand sequences, checked through a
// one-deep-latency scoreboard fed by a behavioural model of the decode table.
module tb_uop_decode_table;
   import ulpsh_uop_pkg::*;

   localparam int NUM_OPS = 81;

   logic        ClockIn = 1'b0;
   logic        ResetIn = 1'b1;
   logic        OpValid_i = 1'b0;
   logic [8:0]  MicroOpCode_i = '0;
   logic [45:0] Signals_o;
   logic        SignalsValid_o, IllegalOp_o, Ready_o;
   logic        CfgWrEn_i = 1'b0;
   logic [8:0]  CfgAddr_i = '0;
   logic [1:0]  CfgSeg_i = '0;
   logic [15:0] CfgData_i = '0;
   logic        CfgClear_i = 1'b0;
   logic        CfgAck_o, CfgErr_o;

   always #5 ClockIn = ~ClockIn;

   uop_decode_table dut (
      .ClockIn        (ClockIn),
      .ResetIn        (ResetIn),
      .OpValid_i      (OpValid_i),
      .MicroOpCode_i  (MicroOpCode_i),
      .Signals_o      (Signals_o),
      .SignalsValid_o (SignalsValid_o),
      .IllegalOp_o    (IllegalOp_o),
      .Ready_o        (Ready_o),
      .CfgWrEn_i      (CfgWrEn_i),
      .CfgAddr_i      (CfgAddr_i),
      .CfgSeg_i       (CfgSeg_i),
      .CfgData_i      (CfgData_i),
      .CfgClear_i     (CfgClear_i),
      .CfgAck_o       (CfgAck_o),
      .CfgErr_o       (CfgErr_o)
   );

   typedef struct packed {
      logic        vld;
      logic        ill;
      logic        rdy;
      logic        ack;
      logic        err;
      logic [45:0] sig;
   } exp_t;

   typedef struct {
      logic        opv;
      logic [8:0]  op;
      logic        wr;
      logic [8:0]  addr;
      logic [1:0]  seg;
      logic [15:0] data;
      exp_t        exp;
   } vec_t;

   exp_t        sbq[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [45:0] model_mem [NUM_OPS];
   logic [31:0] model_stg;
   int          left;
   vec_t        tab [16];

   function automatic vec_t mk(input logic opv, input logic [8:0] op, input logic wr,
                               input logic [8:0] addr, input logic [1:0] seg, input logic [15:0] data,
                               input logic vld, input logic ill, input logic ack, input logic err,
                               input logic [45:0] sig);
      vec_t v;
      v.opv = opv; v.op = op; v.wr = wr; v.addr = addr; v.seg = seg; v.data = data;
      v.exp = {vld, ill, 1'b1, ack, err, sig};
      return v;
   endfunction

   function automatic exp_t sample();
      return {SignalsValid_o, IllegalOp_o, Ready_o, CfgAck_o, CfgErr_o, Signals_o};
   endfunction

   // One clock: drive, predict, push; then pop and compare one time unit after the edge.
   task automatic cyc(input logic opv, input logic [8:0] op, input logic wr, input logic [8:0] addr,
                      input logic [1:0] seg, input logic [15:0] data, input logic clr,
                      input bit use_tab, input exp_t tabexp, input string name);
      exp_t e, got, want;
      logic acc;
      logic [47:0] full;
      OpValid_i = opv; MicroOpCode_i = op; CfgWrEn_i = wr; CfgAddr_i = addr;
      CfgSeg_i = seg; CfgData_i = data; CfgClear_i = clr;
      acc   = (left == 0);
      e     = '0;
      e.vld = acc & opv;
      e.ill = acc & opv & (op >= 9'(NUM_OPS));
      if (e.vld && !e.ill) e.sig = model_mem[op];
      e.ack = acc & wr & ~clr & (seg == 2'd2);
      e.err = e.ack & (addr >= 9'(NUM_OPS));
      if (acc && clr) begin
         for (int i = 0; i < NUM_OPS; i++) model_mem[i] = '0;
         model_stg = '0;
         left = NUM_OPS + 1;
      end else begin
         if (acc && wr && seg == 2'd2 && addr < 9'(NUM_OPS)) begin
            full = {data, model_stg};
            model_mem[addr] = full[45:0];
         end
         if (acc && wr && seg < 2'd2) model_stg[int'(seg)*16 +: 16] = data;
         if (left > 0) left--;
      end
      e.rdy = (left == 0);
      sbq.push_back(use_tab ? tabexp : e);
      @(posedge ClockIn);
      #1;
      got = sample();
      vectors++;
      if (sbq.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty, got %h", name, got);
      end else begin
         want = sbq.pop_front();
         if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got vld=%0b ill=%0b rdy=%0b ack=%0b err=%0b sig=%h, want vld=%0b ill=%0b rdy=%0b ack=%0b err=%0b sig=%h",
                     name, got.vld, got.ill, got.rdy, got.ack, got.err, got.sig,
                     want.vld, want.ill, want.rdy, want.ack, want.err, want.sig);
         end
      end
   endtask

   task automatic idle(input int n, input string name);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, name);
   endtask

   task automatic do_reset(input string name);
      exp_t got;
      #2;
      ResetIn = 1'b1;
      OpValid_i = 1'b0; CfgWrEn_i = 1'b0; CfgClear_i = 1'b0;
      #1;
      got = sample();
      vectors++;
      if (got !== '0) begin
         miscompares++;
         $display("FAIL %s: outputs under reset %h, want 0", name, got);
      end
      sbq.delete();
      for (int i = 0; i < NUM_OPS; i++) model_mem[i] = '0;
      model_stg = '0;
      left = NUM_OPS + 1;
      @(posedge ClockIn);
      @(negedge ClockIn);
      ResetIn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   initial begin
      logic [47:0] img;
      tab[0]  = mk(0, 9'h000, 1, 9'h038, 2'd0, 16'h00F0, 0, 0, 0, 0, 46'h0);
      tab[1]  = mk(0, 9'h000, 1, 9'h038, 2'd1, 16'h0E10, 0, 0, 0, 0, 46'h0);
      tab[2]  = mk(0, 9'h000, 1, 9'h038, 2'd2, 16'h0000, 0, 0, 1, 0, 46'h0);
      tab[3]  = mk(1, 9'h038, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h0000_0E10_00F0);
      tab[4]  = mk(1, 9'h051, 0, 9'h000, 2'd0, 16'h0000, 1, 1, 0, 0, 46'h0);
      tab[5]  = mk(1, 9'h1FF, 0, 9'h000, 2'd0, 16'h0000, 1, 1, 0, 0, 46'h0);
      tab[6]  = mk(0, 9'h000, 1, 9'h060, 2'd2, 16'hBEEF, 0, 0, 1, 1, 46'h0);
      tab[7]  = mk(1, 9'h038, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h0000_0E10_00F0);
      tab[8]  = mk(0, 9'h000, 1, 9'h038, 2'd3, 16'hFFFF, 0, 0, 0, 0, 46'h0);
      tab[9]  = mk(1, 9'h038, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h0000_0E10_00F0);
      tab[10] = mk(0, 9'h000, 1, 9'h010, 2'd2, 16'h1234, 0, 0, 1, 0, 46'h0);
      tab[11] = mk(1, 9'h010, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h1234_0E10_00F0);
      tab[12] = mk(1, 9'h011, 1, 9'h011, 2'd2, 16'hC005, 1, 0, 1, 0, 46'h0);
      tab[13] = mk(1, 9'h011, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h0005_0E10_00F0);
      tab[14] = mk(0, 9'h011, 0, 9'h000, 2'd0, 16'h0000, 0, 0, 0, 0, 46'h0);
      tab[15] = mk(1, 9'h050, 0, 9'h000, 2'd0, 16'h0000, 1, 0, 0, 0, 46'h0);

      do_reset("reset_initial");

      // Opcodes held valid through INIT are ignored; Ready_o rises NUM_OPS+1 edges after release.
      for (int i = 0; i < NUM_OPS + 1; i++)
         cyc(1'b1, 9'(i), 1'b1, 9'(i), 2'd2, 16'hFFFF, 1'b0, 1'b0, '0, "init_hold");
      for (int i = 0; i < NUM_OPS; i++)
         cyc(1'b1, 9'(i), 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "init_zero");

      for (int i = 0; i < 16; i++)
         cyc(tab[i].opv, tab[i].op, tab[i].wr, tab[i].addr, tab[i].seg, tab[i].data, 1'b0,
             1'b1, tab[i].exp, $sformatf("tab%0d", i));

      // Same-cycle commit and decode of 0x021 returns the old word.
      cyc(1'b0, '0, 1'b1, 9'h021, 2'd0, 16'h0001, 1'b0, 1'b0, '0, "rbw_seg0");
      cyc(1'b0, '0, 1'b1, 9'h021, 2'd1, 16'h0000, 1'b0, 1'b0, '0, "rbw_seg1");
      cyc(1'b1, 9'h021, 1'b1, 9'h021, 2'd2, 16'h0000, 1'b0, 1'b0, '0, "rbw_same");
      cyc(1'b1, 9'h021, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "rbw_next");

      // Full random image with random decodes interleaved, then a back-to-back stream.
      for (int a = 0; a < NUM_OPS; a++) begin
         img = {$urandom, $urandom};
         cyc(1'b1, 9'($urandom_range(0, 511)), 1'b1, 9'(a), 2'd0, img[15:0],  1'b0, 1'b0, '0, "load_seg0");
         cyc(1'b1, 9'($urandom_range(0, 511)), 1'b1, 9'(a), 2'd1, img[31:16], 1'b0, 1'b0, '0, "load_seg1");
         cyc(1'b1, 9'($urandom_range(0, 511)), 1'b1, 9'(a), 2'd2, img[47:32], 1'b0, 1'b0, '0, "load_seg2");
      end
      for (int i = 0; i < NUM_OPS; i++)
         cyc(1'b1, 9'(i), 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "stream_image");

      // Clear beats a same-cycle commit; the same-cycle decode still completes.
      cyc(1'b1, 9'h021, 1'b1, 9'h022, 2'd2, 16'h0007, 1'b1, 1'b0, '0, "clear_edge");
      for (int i = 0; i < NUM_OPS + 1; i++)
         cyc(1'b1, 9'(i), 1'b1, 9'h022, 2'd2, 16'h0007, 1'b1, 1'b0, '0, "clear_init");
      for (int i = 0; i < NUM_OPS; i++)
         cyc(1'b1, 9'(i), 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "stream_cleared");

      // Reset mid-INIT, then mid-load with a live decode on the outputs.
      do_reset("reset_pre_mid_init");
      for (int i = 0; i < 40; i++)
         cyc(1'b1, 9'(i), 1'b1, 9'(i), 2'd0, 16'h5555, 1'b0, 1'b0, '0, "init_partial");
      do_reset("reset_mid_init");
      idle(NUM_OPS + 1, "reinit");
      cyc(1'b1, 9'h030, 1'b1, 9'h030, 2'd0, 16'hAAAA, 1'b0, 1'b0, '0, "midload_seg0");
      do_reset("reset_mid_load");
      idle(NUM_OPS + 1, "reinit2");
      cyc(1'b1, 9'h030, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "after_reset_zero");
      cyc(1'b0, '0, 1'b1, 9'h030, 2'd2, 16'h0001, 1'b0, 1'b0, '0, "commit_no_stage");
      cyc(1'b1, 9'h030, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "staging_lost");
      cyc(1'b1, 9'h021, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, "old_entry_gone");
      idle(2, "tail");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
